mu_imem_loader: RTL
===================

Name: mu_imem_loader

Overview:
- Writer-side counterpart to the program instruction memory.
- Accepts a byte stream from a serial or debug front end, assembles 32-bit big-endian instruction words, and issues single-cycle word writes to instruction memory.
- Writes start at the MIPS text base address and advance by 4 bytes per word.
- Holds the CPU in reset until the load completes, so the processor always fetches from a fully written image.

Parameters:
DATA_WIDTH, 32, instruction word / address width
BASE_ADDR, 32'h0040_0000, byte address of the first word written
MAX_WORDS, 64, memory depth in words; larger header counts are rejected

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a load when idle
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts byte this cycle (transfer = rx_valid & rx_ready)
mem_we  output  1  one-cycle word write strobe
mem_addr  output  DATA_WIDTH  byte address of write, BASE_ADDR + 4*index
mem_wdata  output  DATA_WIDTH  assembled word
busy  output  1  load in progress
done  output  1  sticky; load completed successfully
error  output  1  sticky; header count exceeded MAX_WORDS
cpu_hold  output  1  CPU reset request; high from start until done

Behaviour:
- Reset (async, active-high):
  - State IDLE.
  - rx_ready, mem_we, busy, done, error = 0; cpu_hold = 1; mem_addr = BASE_ADDR; mem_wdata = 0.
  - Internal word count, index and byte counter = 0.
- Frame format: 2-byte word count N (high byte first), then 4*N data bytes, each word MSB first.
- States and transitions:
  - IDLE:
    - rx_ready = 0.
    - start -> LEN_HI; done and error cleared; busy = 1; cpu_hold = 1.
  - LEN_HI:
    - rx_ready = 1.
    - On transfer: N[15:8] latched -> LEN_LO.
  - LEN_LO:
    - rx_ready = 1.
    - On transfer: N[7:0] latched, then evaluate the full N:
      - N == 0 -> DONE.
      - N > MAX_WORDS -> ERR.
      - Otherwise -> DATA with index = 0 and byte counter = 0.
  - DATA:
    - rx_ready = 1.
    - Each transfer shifts the byte into the word: word = {word[23:0], rx_data}.
    - The byte counter increments 0..3; on the 4th byte -> WRITE.
  - WRITE (exactly one cycle):
    - rx_ready = 0.
    - mem_we = 1; mem_wdata = assembled word; mem_addr = BASE_ADDR + (index << 2).
    - Then index increments; if index+1 == N -> DONE, else -> DATA.
  - DONE:
    - busy = 0, done = 1, cpu_hold = 0.
    - Remains until start (-> LEN_HI, cpu_hold reasserts) or reset.
  - ERR:
    - busy = 0, error = 1, cpu_hold stays 1; rx_ready = 0.
    - start retries (-> LEN_HI).
- Latency:
  - mem_we asserts the cycle after the clock edge accepting the 4th byte of a word.
  - Minimum 5 cycles per word.
- rx_valid with rx_ready = 0: byte not consumed; source must hold it.
- rx_valid low in LEN_HI/LEN_LO/DATA: state holds indefinitely; no timeout.
- start while busy (LEN_HI..WRITE): ignored.
- Arithmetic and boundaries:
  - mem_addr computed modulo 2^DATA_WIDTH; index width is clog2(MAX_WORDS)+1.
  - N == MAX_WORDS is accepted; the last write goes to BASE_ADDR + 4*(MAX_WORDS-1).
  - N = MAX_WORDS+1 -> ERR, and no mem_we is ever issued.
- Outputs registered:
  - mem_addr and mem_wdata hold their last values outside WRITE.
  - mem_we is never high for more than one consecutive cycle.
- Reset mid-load:
  - Immediate return to IDLE; mem_we drops asynchronously; partially assembled word discarded.
  - cpu_hold = 1; no further writes occur.

Test Plan:
- Reset mid-DATA (after 2 bytes of word 1, rx_valid held high) -> mem_we = 0 immediately, cpu_hold = 1, state IDLE, no write after reset release until new start.
- start, header 00 02, bytes 20 08 00 05 | 01 09 50 20 -> mem_we pulses: addr 0x0040_0000 data 0x2008_0005, then addr 0x0040_0004 data 0x0109_5020; done = 1, cpu_hold = 0.
- start, header 00 00 -> no mem_we, done = 1 two cycles after header low byte, cpu_hold = 0.
- start, header 00 40 (64 words, incrementing data) -> 64 writes, last addr 0x0040_00FC; then header 00 41 after restart -> error = 1, zero writes, cpu_hold = 1.
- Byte gaps (rx_valid toggling randomly) plus rx_valid high during WRITE -> rx_ready = 0 in WRITE, no byte lost or duplicated, words match the byte stream exactly.
- start pulsed during DATA -> ignored; load completes normally with correct addresses.

Source files
------------

// File: rtl/mu_imem_loader.sv
// mu_imem_loader: assembles a length-prefixed big-endian byte stream into instruction memory writes
module mu_imem_loader #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'h0040_0000,
    parameter int                    MAX_WORDS  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_hold
);
    localparam int IW = $clog2(MAX_WORDS) + 1;

    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR} state_t;

    state_t        state, state_nx;
    logic [7:0]    n_hi;
    logic [15:0]   n;
    logic [15:0]   n_full;
    logic [IW-1:0] idx;
    logic [1:0]    cnt;
    logic [23:0]   word;
    logic          can_start;
    logic          last;

    assign n_full    = {n_hi, rx_data};
    assign can_start = start && (state == IDLE || state == DONE || state == ERR);
    assign last      = 16'(idx) + 16'd1 == n;

    // State register; reset drops mem_we and rx_ready immediately since both decode from state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic and state-decoded strobes
    always_comb begin
        state_nx = state;
        rx_ready = 1'b0;
        mem_we   = 1'b0;
        case (state)
            IDLE:    state_nx = start ? LEN_HI : IDLE;
            LEN_HI: begin
                rx_ready = 1'b1;
                state_nx = rx_valid ? LEN_LO : LEN_HI;
            end
            LEN_LO: begin
                rx_ready = 1'b1;
                if (rx_valid)
                    state_nx = n_full == 16'd0              ? DONE :
                               n_full > 16'(MAX_WORDS)      ? ERR  : DATA;
            end
            DATA: begin
                rx_ready = 1'b1;
                state_nx = rx_valid && cnt == 2'd3 ? WRITE : DATA;
            end
            WRITE: begin
                mem_we   = 1'b1;
                state_nx = last ? DONE : DATA;
            end
            DONE:    state_nx = start ? LEN_HI : DONE;
            ERR:     state_nx = start ? LEN_HI : ERR;
            default: state_nx = IDLE;
        endcase
    end

    // Status flags: start clears the sticky flags, terminal states set them one cycle later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
        end else if (can_start) begin
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
        end else if (state == DONE) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
        end else if (state == ERR) begin
            busy     <= 1'b0;
            error    <= 1'b1;
        end
    end

    // Header capture: high byte first, full count kept for the end-of-load compare
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_hi <= 8'd0;
            n    <= 16'd0;
        end else begin
            if (state == LEN_HI && rx_valid) n_hi <= rx_data;
            if (state == LEN_LO && rx_valid) n    <= n_full;
        end
    end

    // Word assembly and index tracking; the write port is loaded on the fourth byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx       <= '0;
            cnt       <= 2'd0;
            word      <= 24'd0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
        end else begin
            if (state == LEN_LO && rx_valid) begin
                idx <= '0;
                cnt <= 2'd0;
            end
            if (state == DATA && rx_valid) begin
                word <= {word[15:0], rx_data};
                cnt  <= cnt + 2'd1;
                if (cnt == 2'd3) begin
                    mem_wdata <= DATA_WIDTH'({word, rx_data});
                    mem_addr  <= BASE_ADDR + (DATA_WIDTH'(idx) << 2);
                end
            end
            if (state == WRITE) idx <= idx + IW'(1);
        end
    end
endmodule
